// File: rtl/instr_sequencer.sv
// Program sequencer: holds DEPTH opcode pairs and issues them to the CPU over a
// valid/ready handshake in free-run, single-step or loop mode, stopping on HALT_OP.
module instr_sequencer #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 16,
  parameter int               AW      = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] HALT_OP = {WIDTH{1'b1}},
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data1,
  input  logic [WIDTH-1:0] wr_data2,
  input  logic             start,
  input  logic             step_mode,
  input  logic             loop_en,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] opcode1,
  output logic [WIDTH-1:0] opcode2,
  output logic [AW-1:0]    pc,
  output logic             busy,
  output logic             done,
  output logic             wr_reject,
  output logic [CNT_W-1:0] issue_count
);

  typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT, DONE} state_t;

  localparam logic [AW-1:0] FIRST = '0;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] mem1 [DEPTH];
  logic [WIDTH-1:0] mem2 [DEPTH];
  logic [WIDTH-1:0] hold1, hold2;

  state_t           state, state_n;
  logic             step_lat, step_lat_n;
  logic             valid_n, busy_n, done_n, wr_reject_n, hold_ld;
  logic [WIDTH-1:0] op1_n, op2_n;
  logic [AW-1:0]    pc_n, nxt_pc;
  logic [CNT_W-1:0] cnt_n;

  // Program memory is only writable while no run is in progress.
  always_ff @(posedge clk) begin
    if (reset && wr_en && (state == IDLE || state == DONE)) begin
      mem1[wr_addr] <= wr_data1;
      mem2[wr_addr] <= wr_data2;
    end
  end

  always_ff @(posedge clk) begin
    if (hold_ld) begin
      hold1 <= mem1[nxt_pc];
      hold2 <= mem2[nxt_pc];
    end
  end

  always_comb begin
    state_n     = state;
    step_lat_n  = step_lat;
    valid_n     = valid;
    op1_n       = opcode1;
    op2_n       = opcode2;
    pc_n        = pc;
    cnt_n       = issue_count;
    done_n      = 1'b0;
    wr_reject_n = 1'b0;
    hold_ld     = 1'b0;
    nxt_pc      = pc + AW'(1);
    case (state)
      IDLE, DONE: begin
        if (start && !wr_en) begin
          pc_n       = '0;
          cnt_n      = '0;
          step_lat_n = step_mode;
          if (mem1[FIRST] == HALT_OP) begin
            state_n = DONE;
            done_n  = 1'b1;
            valid_n = 1'b0;
            op1_n   = '0;
            op2_n   = '0;
          end else begin
            state_n = RUN;
            valid_n = 1'b1;
            op1_n   = mem1[FIRST];
            op2_n   = mem2[FIRST];
          end
        end
      end
      RUN: begin
        wr_reject_n = wr_en;
        if (valid && ready) begin
          cnt_n   = sat_inc(issue_count);
          valid_n = 1'b0;
          op1_n   = '0;
          op2_n   = '0;
          // End-of-program and HALT win over the single-step pause.
          if (pc == LAST && !loop_en) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            pc_n = nxt_pc;
            if (mem1[nxt_pc] == HALT_OP) begin
              state_n = DONE;
              done_n  = 1'b1;
            end else if (step_lat) begin
              state_n = STEP_WAIT;
              hold_ld = 1'b1;
            end else begin
              valid_n = 1'b1;
              op1_n   = mem1[nxt_pc];
              op2_n   = mem2[nxt_pc];
            end
          end
        end
      end
      STEP_WAIT: begin
        wr_reject_n = wr_en;
        if (start) begin
          state_n = RUN;
          valid_n = 1'b1;
          op1_n   = hold1;
          op2_n   = hold2;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN) || (state_n == STEP_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      step_lat    <= 1'b0;
      valid       <= 1'b0;
      opcode1     <= '0;
      opcode2     <= '0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wr_reject   <= 1'b0;
      issue_count <= '0;
    end else begin
      state       <= state_n;
      step_lat    <= step_lat_n;
      valid       <= valid_n;
      opcode1     <= op1_n;
      opcode2     <= op2_n;
      pc          <= pc_n;
      busy        <= busy_n;
      done        <= done_n;
      wr_reject   <= wr_reject_n;
      issue_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed and randomized programs/handshakes checked
// against a transaction-level model of the instruction stream the CPU should see.
module tb_instr_sequencer;

  localparam int               WIDTH   = 8;
  localparam int               DEPTH   = 4;
  localparam int               AW      = 2;
  localparam int               CNT_W   = 4;
  localparam int               CNT_MAX = 15;
  localparam logic [WIDTH-1:0] HALT    = 8'hFF;

  typedef logic [AW+2*WIDTH-1:0] ent_t;

  logic             clk = 1'b0;
  logic             reset, wr_en, start, step_mode, loop_en, ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data1, wr_data2;
  logic             valid, busy, done, wr_reject;
  logic [WIDTH-1:0] opcode1, opcode2;
  logic [AW-1:0]    pc;
  logic [CNT_W-1:0] issue_count;

  instr_sequencer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .HALT_OP(HALT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data1(wr_data1), .wr_data2(wr_data2), .start(start),
    .step_mode(step_mode), .loop_en(loop_en), .ready(ready),
    .valid(valid), .opcode1(opcode1), .opcode2(opcode2), .pc(pc),
    .busy(busy), .done(done), .wr_reject(wr_reject), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] prog1 [DEPTH];
  logic [WIDTH-1:0] prog2 [DEPTH];
  ent_t             exp_q[$];
  ent_t             obs_q[$];
  int               exp_pc, done_cnt;
  bit               mon_en = 1'b0;
  bit               step_g = 1'b0;
  int               loopn_g = 0, rdy_pct_g = 100, stall_at = -1, stall_left = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_cnt(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  // Walk the program as the CPU should see it: stop on HALT, wrap at the end
  // only while the transfer index is below loopn (loop_en is driven that way).
  function automatic void build_model(input int loopn);
    int p = 0;
    exp_q.delete();
    exp_pc = 0;
    for (int i = 0; i < 500; i++) begin
      if (prog1[p] == HALT) begin
        exp_pc = p;
        return;
      end
      exp_q.push_back({p[AW-1:0], prog1[p], prog2[p]});
      exp_pc = p;
      if (p == DEPTH - 1) begin
        if (i < loopn) p = 0;
        else return;
      end else begin
        p = p + 1;
      end
    end
  endfunction

  initial begin
    bit               stall_prev = 1'b0;
    bit               xfer_prev  = 1'b0;
    logic [WIDTH-1:0] s1 = '0, s2 = '0;
    logic [AW-1:0]    spc = '0;
    forever begin
      @(negedge clk);
      if (mon_en && reset) begin
        if (stall_prev) begin
          check_eq("hold_valid", 64'(valid), 64'(1));
          check_eq("hold_op1", 64'(opcode1), 64'(s1));
          check_eq("hold_op2", 64'(opcode2), 64'(s2));
          check_eq("hold_pc", 64'(pc), 64'(spc));
        end
        if (xfer_prev) begin
          if (step_g) check_eq("step_gap", 64'(valid), 64'(0));
          else if (obs_q.size() < exp_q.size()) check_eq("no_bubble", 64'(valid), 64'(1));
        end
        if (!valid) check_eq("idle_opcodes", 64'({opcode1, opcode2}), 64'(0));
        if (busy) check_eq("issue_count", 64'(issue_count), 64'(sat_cnt(obs_q.size())));
      end
      if (done) done_cnt++;
      stall_prev = valid && !ready;
      xfer_prev  = valid && ready;
      s1 = opcode1;
      s2 = opcode2;
      spc = pc;
      if (valid && ready) obs_q.push_back({pc, opcode1, opcode2});
    end
  end

  task automatic drive_cycle();
    @(posedge clk); #1;
    if (stall_left > 0 && obs_q.size() == stall_at) begin
      ready = 1'b0;
      stall_left--;
    end else begin
      ready = ($urandom_range(99) < rdy_pct_g);
    end
    loop_en   = (obs_q.size() < loopn_g);
    step_mode = 1'($urandom_range(1));
    if (busy && !valid && step_g) start = ($urandom_range(2) == 0);
    else if (busy && valid)       start = ($urandom_range(7) == 0);
    else                          start = 1'b0;
  endtask

  task automatic load(input int a, input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2);
    @(posedge clk); #1;
    wr_en    = 1'b1;
    wr_addr  = a[AW-1:0];
    wr_data1 = d1;
    wr_data2 = d2;
    prog1[a] = d1;
    prog2[a] = d2;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check_eq("write_no_reject", 64'(wr_reject), 64'(0));
  endtask

  task automatic launch(input bit step, input int loopn, input int rdy_pct);
    build_model(loopn);
    obs_q.delete();
    done_cnt  = 0;
    step_g    = step;
    loopn_g   = loopn;
    rdy_pct_g = rdy_pct;
    @(posedge clk); #1;
    step_mode = step;
    start     = 1'b1;
    ready     = 1'b0;
    loop_en   = (loopn > 0);
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      drive_cycle();
      cyc++;
    end
    check_eq({tag, "_done_seen"}, 64'(done_cnt > 0), 64'(1));
    repeat (3) drive_cycle();
    check_eq({tag, "_done_once"}, 64'(done_cnt), 64'(1));
    check_eq({tag, "_valid_end"}, 64'(valid), 64'(0));
    check_eq({tag, "_busy_end"}, 64'(busy), 64'(0));
    check_eq({tag, "_pc_end"}, 64'(pc), 64'(exp_pc));
    check_eq({tag, "_count_end"}, 64'(issue_count), 64'(sat_cnt(exp_q.size())));
    check_eq({tag, "_n_xfer"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq({tag, "_xfer"}, 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; wr_en = 1'b0; start = 1'b0; step_mode = 1'b0;
    loop_en = 1'b0; ready = 1'b0; wr_addr = '0; wr_data1 = '0; wr_data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(valid), 64'(0));
    check_eq("rst_op", 64'({opcode1, opcode2}), 64'(0));
    check_eq("rst_pc", 64'(pc), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_wr_reject", 64'(wr_reject), 64'(0));
    check_eq("rst_count", 64'(issue_count), 64'(0));
    reset  = 1'b1;
    mon_en = 1'b1;

    load(0, 8'h10, 8'hFF); load(1, 8'h30, 8'h83);
    load(2, 8'h20, 8'h83); load(3, 8'hFF, 8'h00);
    launch(0, 0, 100); wait_done("basic");
    stall_at = 1; stall_left = 2;
    launch(0, 0, 100); wait_done("stall");
    check_eq("stall_applied", 64'(stall_left), 64'(0));
    launch(1, 0, 100); wait_done("step");

    load(0, 8'h41, 8'h01); load(1, 8'h42, 8'h02);
    load(2, 8'h43, 8'h03); load(3, 8'h44, 8'h04);
    launch(0, 10, 100); wait_done("loop");
    launch(1, 10, 70);  wait_done("loop_step");
    launch(0, 20, 100); wait_done("saturate");

    launch(0, 0, 0);
    drive_cycle();
    check_eq("run_valid", 64'(valid), 64'(1));
    wr_en = 1'b1; wr_addr = 2'd1; wr_data1 = 8'hAA; wr_data2 = 8'hBB;
    drive_cycle();
    wr_en = 1'b0;
    check_eq("wr_reject_pulse", 64'(wr_reject), 64'(1));
    drive_cycle();
    check_eq("wr_reject_clear", 64'(wr_reject), 64'(0));
    rdy_pct_g = 100;
    wait_done("reject");

    launch(0, 100, 80);
    repeat (5) drive_cycle();
    mon_en = 1'b0; reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_valid", 64'(valid), 64'(0));
    check_eq("midrst_pc", 64'(pc), 64'(0));
    check_eq("midrst_busy", 64'(busy), 64'(0));
    check_eq("midrst_count", 64'(issue_count), 64'(0));
    check_eq("midrst_op", 64'({opcode1, opcode2}), 64'(0));
    reset = 1'b1; ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("midrst_no_done", 64'(done_cnt), 64'(0));
    mon_en = 1'b1;

    wr_en = 1'b1; start = 1'b1; wr_addr = 2'd0; wr_data1 = HALT; wr_data2 = 8'h12;
    prog1[0] = HALT; prog2[0] = 8'h12;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    check_eq("wrstart_busy", 64'(busy), 64'(0));
    check_eq("wrstart_valid", 64'(valid), 64'(0));
    check_eq("wrstart_done", 64'(done), 64'(0));
    launch(0, 0, 100);
    drive_cycle();
    check_eq("halt0_done", 64'(done), 64'(1));
    check_eq("halt0_valid", 64'(valid), 64'(0));
    check_eq("halt0_count", 64'(issue_count), 64'(0));
    wait_done("halt0");

    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        logic [WIDTH-1:0] d1;
        d1 = ($urandom_range(4) == 0) ? HALT : WIDTH'($urandom_range(254));
        load(a, d1, WIDTH'($urandom));
      end
      launch(1'($urandom_range(1)), int'($urandom_range(6)), 40 + int'($urandom_range(60)));
      wait_done("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
